sum_bcd_display: RTL and testbench
==================================

SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width (adder result zero-extended into it).
REQ-002 SHALL have parameter BLANK, default 1, 1 = suppress leading zeros on HEX2/HEX1.
REQ-003 SHALL have CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have Resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have value  input  WIDTH  unsigned binary to display.
REQ-006 SHALL have in_valid  input  1  value is presented for conversion.
REQ-007 SHALL have in_ready  output  1  block can accept a value this cycle.
REQ-008 SHALL have busy  output  1  conversion in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse when HEX outputs update.
REQ-010 SHALL have HEX0, HEX1, HEX2  output  7 each  active-low segments {g,f,e,d,c,b,a}: ones, tens, hundreds.

Function
REQ-011 SHALL implement states IDLE, CONV, LOAD.
REQ-012 IDLE: in_ready=1, busy=0; on in_valid=1, capture value into shift register, clear 12-bit BCD register, load bit counter with WIDTH, go to CONV.
REQ-013 Transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_valid outside IDLE is ignored, not queued.
REQ-014 CONV: in_ready=0, busy=1; each cycle, add 3 to every BCD nibble >= 5, then shift {BCD, shift register} left by one; decrement counter.
REQ-015 CONV SHALL perform exactly WIDTH shifts, then go to LOAD.
REQ-016 LOAD: register HEX0..HEX2 from BCD digits, assert done for this one cycle, return to IDLE; busy=1, in_ready=0.
REQ-017 Latency: value captured at edge k SHALL appear on HEX outputs after edge k+WIDTH+1; next value acceptable at edge k+WIDTH+2.
REQ-018 Segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 BLANK=1: HEX2 = 1111111 when hundreds digit is 0; HEX1 = 1111111 when hundreds and tens are both 0; HEX0 always shows a digit.
REQ-020 BLANK=0: all three displays SHALL show their digit, including leading zeros.
REQ-021 HEX outputs SHALL hold their last value through IDLE and CONV; change only in LOAD.
REQ-022 WIDTH SHALL be 1..9 (max 511 fits three digits); BCD nibbles SHALL never exceed 9 after LOAD.
REQ-023 Value input SHALL be sampled only at capture; changes during CONV do not affect the result.

Reset
REQ-024 Resetn=0 at a rising edge SHALL force IDLE, counter=0, shift/BCD registers=0, done=0, busy=0, in_ready=1 after that edge.
REQ-025 After reset HEX0 SHALL be 1000000 ("0"); HEX1, HEX2 SHALL be 1111111 when BLANK=1, 1000000 when BLANK=0.
REQ-026 Reset during CONV or LOAD SHALL abort conversion with no done pulse and no HEX update beyond the reset values.
REQ-027 Reset SHALL take priority over in_valid in the same cycle.

Verification
REQ-028 WIDTH=8, BLANK=1: value=8'd5, in_valid pulse -> after 9 edges HEX0=0010010, HEX1=HEX2=1111111, done high exactly one cycle.
REQ-029 WIDTH=8: value=8'd255 -> HEX2=0100100, HEX1=0010010, HEX0=0010010; value=8'd100 -> HEX2=1111001, HEX1=HEX0=1000000.
REQ-030 WIDTH=5 (adder output), BLANK=0: value=5'd31 -> HEX2=1000000, HEX1=0110000, HEX0=1111001 after 6 edges.
REQ-031 Hold in_valid=1 continuously with value changing every cycle -> one conversion per WIDTH+2 cycles, each displaying the value present at its capture edge.
REQ-032 Assert Resetn=0 mid-CONV of value 8'd200 -> no done pulse, HEX returns to reset pattern, in_ready=1 the next cycle.
REQ-033 Exhaustive WIDTH=8 sweep 0..255 -> decoded HEX digits equal value/100, (value/10)%10, value%10 with correct blanking.

Source files
------------

// File: rtl/sum_bcd_display_if.sv
// Bus bundle for sum_bcd_display: one binary value in, three 7-segment digits out.
//
// Handshake: a value transfers on a rising clock edge where in_valid=1 and in_ready=1.
// in_ready is high only while the converter is idle; in_valid at any other time is
// ignored (not queued), and the producer need not hold value after the transfer edge.
// done pulses for one cycle while the HEX registers are being loaded; the new digits
// are visible after the edge that ends that cycle.
interface sum_bcd_display_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [6:0]       HEX0;
    logic [6:0]       HEX1;
    logic [6:0]       HEX2;

    modport master (
        output value, in_valid,
        input  in_ready, busy, done, HEX0, HEX1, HEX2
    );

    modport slave (
        input  value, in_valid,
        output in_ready, busy, done, HEX0, HEX1, HEX2
    );
endinterface

// File: rtl/sum_bcd_display.sv
// Binary-to-BCD converter (shift-and-add-3) driving three active-low 7-segment
// displays {g,f,e,d,c,b,a}: HEX0 ones, HEX1 tens, HEX2 hundreds.
// One value is converted in WIDTH cycles, then the displays are loaded in one cycle.
module sum_bcd_display #(
    parameter int WIDTH = 8,  // 1..9, so the result fits three BCD digits
    parameter bit BLANK = 1   // 1 = blank leading zeros on HEX2/HEX1
) (
    input  logic                   CLOCK_50,
    input  logic                   Resetn,
    sum_bcd_display_if.slave       bus,
    output logic [1:0]             state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT  = 4'(WIDTH);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    // Leading digits after reset show the same thing a converted zero would.
    localparam logic [6:0] SEG_LEAD  = BLANK ? SEG_BLANK : SEG_ZERO;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       hex0_q, hex0_d;
    logic [6:0]       hex1_q, hex1_d;
    logic [6:0]       hex2_q, hex2_d;
    logic [11:0]      bcd_adj;

    // Decimal digit to active-low segment pattern; anything above 9 is blanked.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, so the following shift
    // carries correctly into the next decimal digit.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_q);

    // Next-state, datapath and display-load decisions.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hex0_d  = hex0_q;
        hex1_d  = hex1_q;
        hex2_d  = hex2_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sh_d    = bus.value;
                    bcd_d   = 12'd0;
                    cnt_d   = CNT_INIT;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[10:0], sh_q[WIDTH-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hex0_d = seg7(bcd_q[3:0]);
                hex1_d = (BLANK && bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
                hex2_d = (BLANK && bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any pending transfer.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex0_q  <= SEG_ZERO;
            hex1_q  <= SEG_LEAD;
            hex2_q  <= SEG_LEAD;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    // Suppressed when reset lands on the LOAD cycle, since that load is aborted.
    assign bus.done     = (state_q == LOAD) && Resetn;
    assign bus.HEX0     = hex0_q;
    assign bus.HEX1     = hex1_q;
    assign bus.HEX2     = hex2_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: an 8-bit blanking instance and a 5-bit non-blanking
// instance share clock and reset, each tracked by a latency/decimal model.
module tb_sum_bcd_display;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] st8, st5;
    bit         chk_en = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk = ~clk;

    sum_bcd_display_if #(.WIDTH(8)) bus8();
    sum_bcd_display_if #(.WIDTH(5)) bus5();

    sum_bcd_display #(.WIDTH(8), .BLANK(1)) dut8 (
        .CLOCK_50    (clk),
        .Resetn      (rstn),
        .bus         (bus8),
        .state_dbg_o (st8)
    );

    sum_bcd_display #(.WIDTH(5), .BLANK(0)) dut5 (
        .CLOCK_50    (clk),
        .Resetn      (rstn),
        .bus         (bus5),
        .state_dbg_o (st5)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // {HEX2, HEX1, HEX0} for a decimal value under the blanking rule.
    function automatic logic [20:0] exp_hex(input int v, input bit blank);
        int d2, d1, d0;
        logic [6:0] h2, h1, h0;
        d2 = v / 100;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        h0 = seg(d0);
        h1 = (blank && d2 == 0 && d1 == 0) ? 7'h7F : seg(d1);
        h2 = (blank && d2 == 0) ? 7'h7F : seg(d2);
        return {h2, h1, h0};
    endfunction

    // ---------------- behavioural model ----------------
    // rem = edges until the block is ready again; displays change as it reaches 0.
    int          rem8 = 0, rem5 = 0;
    logic [20:0] hex8_m, hex5_m;
    logic [7:0]  exp_q8[$];
    logic [4:0]  exp_q5[$];

    always @(posedge clk) begin
        if (!rstn) begin
            rem8 = 0; exp_q8.delete(); hex8_m = exp_hex(0, 1'b1);
            rem5 = 0; exp_q5.delete(); hex5_m = exp_hex(0, 1'b0);
        end else begin
            if (rem8 == 0) begin
                if (bus8.in_valid) begin exp_q8.push_back(bus8.value); rem8 = 8 + 1; end
            end else begin
                rem8--;
                if (rem8 == 0) hex8_m = exp_hex(int'(exp_q8.pop_front()), 1'b1);
            end
            if (rem5 == 0) begin
                if (bus5.in_valid) begin exp_q5.push_back(bus5.value); rem5 = 5 + 1; end
            end else begin
                rem5--;
                if (rem5 == 0) hex5_m = exp_hex(int'(exp_q5.pop_front()), 1'b0);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready8", bus8.in_ready, rem8 == 0);
            chk("busy8",  bus8.busy,     rem8 != 0);
            chk("done8",  bus8.done,     (rem8 == 1) && rstn);
            chk("hex8",   {bus8.HEX2, bus8.HEX1, bus8.HEX0}, hex8_m);
            chk("ready5", bus5.in_ready, rem5 == 0);
            chk("busy5",  bus5.busy,     rem5 != 0);
            chk("done5",  bus5.done,     (rem5 == 1) && rstn);
            chk("hex5",   {bus5.HEX2, bus5.HEX1, bus5.HEX0}, hex5_m);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] v);
        int n = 0;
        while (!bus8.in_ready && n < 50) begin tick(); n++; end
        chk("idle8_wait", bus8.in_ready, 1);
        bus8.value    = v;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.value    = 8'($urandom);
    endtask

    task automatic send5(input logic [4:0] v);
        int n = 0;
        while (!bus5.in_ready && n < 50) begin tick(); n++; end
        chk("idle5_wait", bus5.in_ready, 1);
        bus5.value    = v;
        bus5.in_valid = 1'b1;
        tick();
        bus5.in_valid = 1'b0;
        bus5.value    = 5'($urandom);
    endtask

    // Returns edges from the capture edge until done was seen, then steps past LOAD.
    task automatic wait_done8(output int n);
        n = 0;
        while (!bus8.done && n < 50) begin tick(); n++; end
        chk("done8_seen", bus8.done, 1);
        tick();
    endtask

    task automatic wait_done5(output int n);
        n = 0;
        while (!bus5.done && n < 50) begin tick(); n++; end
        chk("done5_seen", bus5.done, 1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bus8.value = '0; bus8.in_valid = 1'b0;
        bus5.value = '0; bus5.in_valid = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        chk("rst8_hex0", bus8.HEX0, 7'b1000000);
        chk("rst8_hex1", bus8.HEX1, 7'b1111111);
        chk("rst8_hex2", bus8.HEX2, 7'b1111111);
        chk("rst8_ready", bus8.in_ready, 1);
        chk("rst8_busy", bus8.busy, 0);
        chk("rst5_hex2", bus5.HEX2, 7'b1000000);
        chk("rst5_hex1", bus5.HEX1, 7'b1000000);
        rstn = 1'b1;
        tick();

        // Directed values with hand-computed displays.
        send8(8'd5);
        wait_done8(lat);
        chk("lat_5", lat, 8);
        chk("v5_hex0", bus8.HEX0, 7'b0010010);
        chk("v5_hex1", bus8.HEX1, 7'b1111111);
        chk("v5_hex2", bus8.HEX2, 7'b1111111);
        chk("v5_done_once", bus8.done, 0);

        send8(8'd255);
        wait_done8(lat);
        chk("v255_hex", {bus8.HEX2, bus8.HEX1, bus8.HEX0}, {7'b0100100, 7'b0010010, 7'b0010010});

        send8(8'd100);
        wait_done8(lat);
        chk("v100_hex", {bus8.HEX2, bus8.HEX1, bus8.HEX0}, {7'b1111001, 7'b1000000, 7'b1000000});

        send5(5'd31);
        wait_done5(lat);
        chk("lat5_31", lat, 5);
        chk("v31_hex", {bus5.HEX2, bus5.HEX1, bus5.HEX0}, {7'b1000000, 7'b0110000, 7'b1111001});

        send5(5'd7);
        wait_done5(lat);
        chk("v7_hex", {bus5.HEX2, bus5.HEX1, bus5.HEX0}, {7'b1000000, 7'b1000000, 7'b1111000});

        // Full 8-bit sweep.
        for (int v = 0; v < 256; v++) begin
            send8(8'(v));
            wait_done8(lat);
            chk("sweep_hex", {bus8.HEX2, bus8.HEX1, bus8.HEX0}, exp_hex(v, 1'b1));
        end

        // in_valid held high with a new value every cycle.
        begin
            int dones = 0;
            for (int i = 0; i < 200; i++) begin
                bus8.value    = 8'($urandom_range(0, 255));
                bus8.in_valid = 1'b1;
                bus5.value    = 5'($urandom_range(0, 31));
                bus5.in_valid = 1'b1;
                tick();
                if (bus8.done) dones++;
            end
            bus8.in_valid = 1'b0;
            bus5.in_valid = 1'b0;
            chk("stream_rate8", (dones >= 19 && dones <= 20), 1);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            bus8.in_valid = 1'($urandom_range(0, 1));
            bus8.value    = 8'($urandom);
            bus5.in_valid = 1'($urandom_range(0, 1));
            bus5.value    = 5'($urandom);
            rstn          = ($urandom_range(0, 40) != 0);
            tick();
        end
        rstn = 1'b1;
        bus8.in_valid = 1'b0;
        bus5.in_valid = 1'b0;
        repeat (12) tick();

        // Reset in the middle of converting 200.
        send8(8'd200);
        repeat (4) tick();
        chk("mid_busy", bus8.busy, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_ready", bus8.in_ready, 1);
        chk("abort_done", bus8.done, 0);
        chk("abort_hex", {bus8.HEX2, bus8.HEX1, bus8.HEX0}, {7'b1111111, 7'b1111111, 7'b1000000});
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_done", bus8.done, 0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
